// File: rtl/axis_round_sat_multi_if.sv
// Stream bundle for axis_round_sat_multi: input beat (i_*) and rounded output beat (o_*).
//   slave  : the rounding stage's view (consumes i_*, produces o_*)
//   master : the surrounding environment's view (produces i_*, consumes o_*)
// Signals:
//   i_tdata  NUM_CHAN*BITS_IN              packed signed input samples, chan 0 in LSBs
//   i_tlast / i_tvalid / i_tready          input handshake
//   o_tdata  NUM_CHAN*BITS_OUT             packed rounded samples
//   o_terr   NUM_CHAN*(BITS_IN-BITS_OUT+1) per-channel signed rounding error
//   o_tclip  NUM_CHAN                      per-channel saturation flag
//   o_tlast / o_tvalid / o_tready          output handshake
interface axis_round_sat_multi_if #(
  parameter int unsigned NUM_CHAN = 1,
  parameter int unsigned BITS_IN  = 24,
  parameter int unsigned BITS_OUT = 16
);
  localparam int unsigned ERR_W = BITS_IN - BITS_OUT + 1;

  logic [NUM_CHAN*BITS_IN-1:0]  i_tdata;
  logic                         i_tlast;
  logic                         i_tvalid;
  logic                         i_tready;

  logic [NUM_CHAN*BITS_OUT-1:0] o_tdata;
  logic [NUM_CHAN*ERR_W-1:0]    o_terr;
  logic [NUM_CHAN-1:0]          o_tclip;
  logic                         o_tlast;
  logic                         o_tvalid;
  logic                         o_tready;

  modport slave (
    input  i_tdata, i_tlast, i_tvalid, o_tready,
    output i_tready, o_tdata, o_terr, o_tclip, o_tlast, o_tvalid
  );

  modport master (
    output i_tdata, i_tlast, i_tvalid, o_tready,
    input  i_tready, o_tdata, o_terr, o_tclip, o_tlast, o_tvalid
  );
endinterface

// File: rtl/axis_round_sat_multi.sv
// Multi-channel two-stage rounding/saturation stage on an AXI-Stream style bundle.
// Each beat carries NUM_CHAN signed BITS_IN samples; the top BITS_OUT bits are kept with a
// run-time rounding mode and saturated to max positive on overflow.
// Ports:
//   clk        clock
//   reset_n    asynchronous active-low reset
//   mode       00 trunc, 01 to-zero, 10 nearest half-up, 11 convergent; sampled per input beat
//   clear_clip synchronous clear of clip_count (wins over a same-cycle increment)
//   bus        stream bundle (slave modport), see axis_round_sat_multi_if
//   clip_count saturating count of accepted output beats with any clip flag set
module axis_round_sat_multi #(
  parameter int unsigned NUM_CHAN = 1,
  parameter int unsigned BITS_IN  = 24,
  parameter int unsigned BITS_OUT = 16,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [1:0]               mode,
  input  logic                     clear_clip,
  axis_round_sat_multi_if.slave    bus,
  output logic [CNT_W-1:0]         clip_count
);
  localparam int unsigned K     = BITS_IN - BITS_OUT;
  localparam int unsigned ERR_W = K + 1;

  typedef enum logic [1:0] {
    RND_TRUNC   = 2'b00,
    RND_ZERO    = 2'b01,
    RND_NEAREST = 2'b10,
    RND_CONV    = 2'b11
  } rnd_mode_e;

  logic adv1, adv2;

  // Stage 1: raw sample, per-channel correction bit, last
  logic                         v1_q, v1_d;
  logic [NUM_CHAN*BITS_IN-1:0]  d1_q, d1_d;
  logic [NUM_CHAN-1:0]          c1_q, c1_d;
  logic                         last1_q, last1_d;

  // Stage 2: rounded result
  logic                         v2_q, v2_d;
  logic [NUM_CHAN*BITS_OUT-1:0] out2_q, out2_d;
  logic [NUM_CHAN*ERR_W-1:0]    err2_q, err2_d;
  logic [NUM_CHAN-1:0]          clip2_q, clip2_d;
  logic                         last2_q, last2_d;

  logic [CNT_W-1:0]             cnt_q, cnt_d;

  logic [NUM_CHAN-1:0]          c_in;
  logic [NUM_CHAN*BITS_OUT-1:0] out_c;
  logic [NUM_CHAN*ERR_W-1:0]    err_c;
  logic [NUM_CHAN-1:0]          clip_c;

  for (genvar ch = 0; ch < NUM_CHAN; ch++) begin : g_chan
    localparam int unsigned LO = ch * BITS_IN;

    logic [K-1:0]      frac_in;
    logic              sgn_in;
    logic              lsb_in;
    logic              c;
    logic [BITS_IN-1:0] s1;
    logic [BITS_OUT:0]  sum;
    logic               clip;
    logic [BITS_OUT-1:0] rnd;

    assign frac_in = bus.i_tdata[LO +: K];
    assign sgn_in  = bus.i_tdata[LO + BITS_IN - 1];
    assign lsb_in  = bus.i_tdata[LO + K];

    always_comb begin
      c = 1'b0;
      case (rnd_mode_e'(mode))
        RND_TRUNC:   c = 1'b0;
        RND_ZERO:    c = sgn_in & (|frac_in);
        RND_NEAREST: c = frac_in[K-1];
        RND_CONV:    c = frac_in[K-1] & ((|frac_in[K-2:0]) | lsb_in);
        default:     c = 1'b0;
      endcase
    end
    assign c_in[ch] = c;

    // c is never negative, so only the positive overflow case needs a clamp.
    assign s1   = d1_q[LO +: BITS_IN];
    assign sum  = {s1[BITS_IN-1], s1[BITS_IN-1:K]} + (BITS_OUT+1)'(c1_q[ch]);
    assign clip = ~sum[BITS_OUT] & sum[BITS_OUT-1];
    assign rnd  = clip ? {1'b0, {(BITS_OUT-1){1'b1}}} : sum[BITS_OUT-1:0];

    assign out_c[ch*BITS_OUT +: BITS_OUT] = rnd;
    assign clip_c[ch]                     = clip;
    // The error fits K+1 bits, so only the low K+1 bits of in-(out<<K) are formed;
    // out<<K contributes just out[0] to that window.
    assign err_c[ch*ERR_W +: ERR_W] = s1[K:0] - {rnd[0], {K{1'b0}}};
  end

  assign adv2         = ~v2_q | bus.o_tready;
  assign adv1         = ~v1_q | adv2;
  assign bus.i_tready = adv1;

  always_comb begin
    v1_d    = v1_q;
    d1_d    = d1_q;
    c1_d    = c1_q;
    last1_d = last1_q;
    if (adv1) begin
      v1_d = bus.i_tvalid;
      if (bus.i_tvalid) begin
        d1_d    = bus.i_tdata;
        c1_d    = c_in;
        last1_d = bus.i_tlast;
      end
    end

    v2_d    = v2_q;
    out2_d  = out2_q;
    err2_d  = err2_q;
    clip2_d = clip2_q;
    last2_d = last2_q;
    if (adv2) begin
      v2_d = v1_q;
      if (v1_q) begin
        out2_d  = out_c;
        err2_d  = err_c;
        clip2_d = clip_c;
        last2_d = last1_q;
      end
    end

    cnt_d = cnt_q;
    if (clear_clip) begin
      cnt_d = '0;
    end else if (v2_q && bus.o_tready && (|clip2_q) && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_q    <= 1'b0;
      d1_q    <= '0;
      c1_q    <= '0;
      last1_q <= 1'b0;
      v2_q    <= 1'b0;
      out2_q  <= '0;
      err2_q  <= '0;
      clip2_q <= '0;
      last2_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      v1_q    <= v1_d;
      d1_q    <= d1_d;
      c1_q    <= c1_d;
      last1_q <= last1_d;
      v2_q    <= v2_d;
      out2_q  <= out2_d;
      err2_q  <= err2_d;
      clip2_q <= clip2_d;
      last2_q <= last2_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.o_tvalid = v2_q;
  assign bus.o_tdata  = out2_q;
  assign bus.o_terr   = err2_q;
  assign bus.o_tclip  = clip2_q;
  assign bus.o_tlast  = last2_q;
  assign clip_count   = cnt_q;
endmodule

// File: tb/tb_axis_round_sat_multi.sv
module tb_axis_round_sat_multi;
  localparam int unsigned NC = 2;
  localparam int unsigned BI = 8;
  localparam int unsigned BO = 4;
  localparam int unsigned CW = 4;
  localparam int unsigned EW = BI - BO + 1;

  typedef struct packed {
    logic [NC*BO-1:0] data;
    logic [NC*EW-1:0] err;
    logic [NC-1:0]    clip;
    logic             last;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    mode;
  logic          clear_clip;
  logic [CW-1:0] clip_count;

  axis_round_sat_multi_if #(.NUM_CHAN(NC), .BITS_IN(BI), .BITS_OUT(BO)) bus ();

  axis_round_sat_multi #(
    .NUM_CHAN(NC), .BITS_IN(BI), .BITS_OUT(BO), .CNT_W(CW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .mode       (mode),
    .clear_clip (clear_clip),
    .bus        (bus),
    .clip_count (clip_count)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  int   cnt_m = 0;
  int   rdy_pct = 100;
  bit   rand_clr = 0;

  // Reference: value/16 rounded per mode using plain integer arithmetic.
  function automatic exp_t model(input logic [1:0] m, input logic [NC*BI-1:0] d, input logic l);
    exp_t e;
    logic [7:0] b;
    int v, rem, fl, r, er;
    logic [31:0] ru, eu;
    e = '0;
    e.last = l;
    for (int ch = 0; ch < NC; ch++) begin
      b   = d[ch*BI +: BI];
      v   = int'($signed(b));
      rem = ((v % 16) + 16) % 16;
      fl  = (v - rem) / 16;
      case (m)
        2'd0: r = fl;
        2'd1: r = (v < 0 && rem != 0) ? fl + 1 : fl;
        2'd2: r = (rem >= 8) ? fl + 1 : fl;
        default: begin
          if (rem > 8) r = fl + 1;
          else if (rem == 8) r = (fl % 2 != 0) ? fl + 1 : fl;
          else r = fl;
        end
      endcase
      e.clip[ch] = (r > 7);
      if (r > 7) r = 7;
      er = v - r * 16;
      ru = r;
      eu = er;
      e.data[ch*BO +: BO] = ru[3:0];
      e.err[ch*EW +: EW]  = eu[4:0];
    end
    return e;
  endfunction

  function automatic exp_t mk(input logic [3:0] o0, input logic [4:0] e0, input logic c0,
                              input logic [3:0] o1, input logic [4:0] e1, input logic c1,
                              input logic l);
    exp_t e;
    e.data = {o1, o0};
    e.err  = {e1, e0};
    e.clip = {c1, c0};
    e.last = l;
    return e;
  endfunction

  function automatic logic [7:0] rand_byte();
    logic [7:0] t;
    t = 8'($urandom);
    case ($urandom_range(0, 4))
      0: return {4'h7, t[3:0]};
      1: return {t[3:0], 4'h8};
      2: return 8'h80;
      default: return t;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic send_beat(input logic [1:0] m, input logic [NC*BI-1:0] d, input logic l,
                           input bit use_ex, input exp_t ex);
    bit acc;
    @(posedge clk); #1;
    mode         = m;
    bus.i_tdata  = d;
    bus.i_tlast  = l;
    bus.i_tvalid = 1'b1;
    clear_clip   = rand_clr && ($urandom_range(0, 31) == 0);
    acc = 0;
    for (int n = 0; n < 300 && !acc; n++) begin
      @(negedge clk);
      if (bus.i_tready) begin
        acc = 1;
        sb_q.push_back(use_ex ? ex : model(m, d, l));
      end else begin
        @(posedge clk); #1;
        clear_clip = rand_clr && ($urandom_range(0, 31) == 0);
      end
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=no_handshake required=handshake");
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.i_tvalid = 1'b0;
      bus.i_tdata  = 16'($urandom);
      mode         = 2'($urandom);
      clear_clip   = 1'b0;
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 1000 && sb_q.size() != 0; n++) @(negedge clk);
    chk("drain_pending", sb_q.size(), 0);
  endtask

  // Output ready driver
  initial begin
    bus.o_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rdy_pct >= 100) bus.o_tready = 1'b1;
      else if (rdy_pct <= 0) bus.o_tready = 1'b0;
      else bus.o_tready = ($urandom_range(0, 99) < rdy_pct);
    end
  end

  // Monitor: compares each presented beat with the scoreboard head and tracks clip_count.
  always @(negedge clk) begin
    exp_t got;
    logic pop_clip;
    if (!reset_n) begin
      sb_q.delete();
      cnt_m = 0;
    end else begin
      pop_clip = 1'b0;
      if (bus.o_tvalid) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_beat actual=valid required=no_beat");
        end else begin
          got.data = bus.o_tdata;
          got.err  = bus.o_terr;
          got.clip = bus.o_tclip;
          got.last = bus.o_tlast;
          checks++;
          if (got !== sb_q[0]) begin
            errors++;
            $display("FAIL beat actual data=%h err=%h clip=%b last=%b required data=%h err=%h clip=%b last=%b",
                     got.data, got.err, got.clip, got.last,
                     sb_q[0].data, sb_q[0].err, sb_q[0].clip, sb_q[0].last);
          end
          if (bus.o_tready) begin
            pop_clip = |sb_q[0].clip;
            void'(sb_q.pop_front());
          end
        end
      end
      checks++;
      if (32'(clip_count) !== 32'(cnt_m)) begin
        errors++;
        $display("FAIL clip_count actual=%0d required=%0d", clip_count, cnt_m);
      end
      if (clear_clip) cnt_m = 0;
      else if (pop_clip && cnt_m != 15) cnt_m++;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  exp_t dir_ex[6];
  logic [1:0]  dir_m[6];
  logic [15:0] dir_d[6];

  initial begin
    int acc, lat;
    bit need_new, got_v;
    logic [15:0] d;

    reset_n      = 1'b0;
    mode         = 2'b00;
    clear_clip   = 1'b0;
    bus.i_tvalid = 1'b0;
    bus.i_tdata  = '0;
    bus.i_tlast  = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_o_tvalid", bus.o_tvalid, 0);
    chk("rst_o_tdata", bus.o_tdata, 0);
    chk("rst_o_terr", bus.o_terr, 0);
    chk("rst_o_tclip", bus.o_tclip, 0);
    chk("rst_o_tlast", bus.o_tlast, 0);
    chk("rst_clip_count", clip_count, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_i_tready", bus.i_tready, 1);

    // Directed beats: {ch1, ch0}
    dir_m[0] = 2'd2; dir_d[0] = 16'hE818; dir_ex[0] = mk(4'h2, 5'h18, 0, 4'hF, 5'h18, 0, 0);
    dir_m[1] = 2'd2; dir_d[1] = 16'h187F; dir_ex[1] = mk(4'h7, 5'h0F, 1, 4'h2, 5'h18, 0, 0);
    dir_m[2] = 2'd3; dir_d[2] = 16'h2818; dir_ex[2] = mk(4'h2, 5'h18, 0, 4'h2, 5'h08, 0, 0);
    dir_m[3] = 2'd3; dir_d[3] = 16'h1829; dir_ex[3] = mk(4'h3, 5'h19, 0, 4'h2, 5'h18, 0, 0);
    dir_m[4] = 2'd1; dir_d[4] = 16'h18F1; dir_ex[4] = mk(4'h0, 5'h11, 0, 4'h1, 5'h08, 0, 0);
    dir_m[5] = 2'd0; dir_d[5] = 16'hF118; dir_ex[5] = mk(4'h1, 5'h08, 0, 4'hF, 5'h01, 0, 1);
    for (int i = 0; i < 6; i++) send_beat(dir_m[i], dir_d[i], dir_ex[i].last, 1, dir_ex[i]);
    idle(1);
    drain();

    // Latency with no backpressure
    idle(3);
    send_beat(2'd2, 16'h3344, 1'b1, 0, '0);
    lat = 0;
    got_v = 0;
    for (int n = 0; n < 10 && !got_v; n++) begin
      if (n == 0) begin
        @(posedge clk); #1;
        bus.i_tvalid = 1'b0;
      end
      @(negedge clk);
      lat++;
      got_v = bus.o_tvalid;
    end
    chk("latency", lat, 2);
    drain();

    // Stall: o_tready low for 5 clocks with continuous input
    rdy_pct  = 0;
    acc      = 0;
    need_new = 1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (need_new) begin
        d = {rand_byte(), rand_byte()};
        mode         = 2'($urandom);
        bus.i_tdata  = d;
        bus.i_tlast  = 1'($urandom);
        bus.i_tvalid = 1'b1;
      end
      @(negedge clk);
      if (bus.i_tready) begin
        sb_q.push_back(model(mode, bus.i_tdata, bus.i_tlast));
        acc++;
        need_new = 1;
      end else begin
        need_new = 0;
      end
    end
    chk("stall_accepted", acc, 2);
    chk("stall_i_tready", bus.i_tready, 0);
    rdy_pct = 100;
    got_v = 0;
    for (int n = 0; n < 20 && !got_v; n++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (bus.i_tready) begin
        sb_q.push_back(model(mode, bus.i_tdata, bus.i_tlast));
        got_v = 1;
      end
    end
    chk("stall_release_accept", got_v, 1);
    idle(1);
    drain();

    // Randomized traffic with mode switching and random clears
    rand_clr = 1;
    for (int i = 0; i < 6000; i++) begin
      send_beat(2'($urandom), {rand_byte(), rand_byte()}, 1'($urandom_range(0, 7) == 0), 0, '0);
      if (i % 500 == 0) rdy_pct = $urandom_range(30, 100);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rand_clr = 0;
    rdy_pct  = 100;
    idle(1);
    drain();

    // Reset mid-packet with beats in flight
    rdy_pct = 0;
    send_beat(2'd2, 16'h7F7F, 1'b0, 0, '0);
    send_beat(2'd2, 16'h7F7F, 1'b0, 0, '0);
    @(posedge clk); #1;
    reset_n      = 1'b0;
    bus.i_tvalid = 1'b0;
    #1;
    chk("midrst_o_tvalid", bus.o_tvalid, 0);
    chk("midrst_o_tclip", bus.o_tclip, 0);
    chk("midrst_o_tdata", bus.o_tdata, 0);
    repeat (2) @(negedge clk);
    rdy_pct = 100;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("postrst_i_tready", bus.i_tready, 1);
    for (int n = 0; n < 3; n++) begin
      chk("postrst_o_tvalid", bus.o_tvalid, 0);
      @(negedge clk);
    end

    // clip_count saturation and clear priority
    @(posedge clk); #1;
    clear_clip = 1'b1;
    @(posedge clk); #1;
    clear_clip = 1'b0;
    for (int i = 0; i < 20; i++) send_beat(2'd2, 16'h007F, 1'b0, 0, '0);
    idle(1);
    drain();
    @(negedge clk);
    chk("clip_count_sat", clip_count, 4'hF);
    rdy_pct = 0;
    send_beat(2'd2, 16'h7F00, 1'b0, 0, '0);
    send_beat(2'd2, 16'h7F00, 1'b1, 0, '0);
    rdy_pct = 100;
    @(posedge clk); #1;
    bus.i_tvalid = 1'b0;
    clear_clip   = 1'b1;
    @(negedge clk);
    chk("clear_pre_count", clip_count, 4'hF);
    chk("clear_beat_clip", bus.o_tvalid & bus.o_tready & (|bus.o_tclip), 1);
    rdy_pct = 0;
    @(posedge clk); #1;
    clear_clip = 1'b0;
    @(negedge clk);
    chk("clear_priority", clip_count, 0);
    rdy_pct = 100;
    drain();
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
